// File: rtl/div_unit_if.sv
// Divider handshake/data bundle between the control unit and div_unit.
//   DivCtrl  : start request (level; a rising edge launches a division)
//   RegA     : signed dividend, sampled on an accepted start
//   RegB     : signed divisor, sampled on an accepted start
//   DivOut   : one-cycle pulse, HIOut/LOOut just updated
//   divZero  : one-cycle pulse, divisor was zero and nothing was computed
//   HIOut    : remainder (takes the sign of the dividend)
//   LOOut    : quotient (truncated toward zero)
// master = control-unit side, slave = divider side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             DivCtrl;
    logic [WIDTH-1:0] RegA;
    logic [WIDTH-1:0] RegB;
    logic             DivOut;
    logic             divZero;
    logic [WIDTH-1:0] HIOut;
    logic [WIDTH-1:0] LOOut;

    modport master (
        output DivCtrl,
        output RegA,
        output RegB,
        input  DivOut,
        input  divZero,
        input  HIOut,
        input  LOOut
    );

    modport slave (
        input  DivCtrl,
        input  RegA,
        input  RegB,
        output DivOut,
        output divZero,
        output HIOut,
        output LOOut
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle signed divider, restoring algorithm, one quotient bit per clock.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous reset, active-low
//   bus   : div_unit_if slave modport (DivCtrl/RegA/RegB in; DivOut/divZero/HIOut/LOOut out)
// Flow: IDLE -> CALC (WIDTH steps) -> FIX (sign fix-up, DivOut pulse) -> IDLE,
//       or IDLE -> ZERO (divZero pulse) -> IDLE for a zero divisor.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] ZERO = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             divctrl_q;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;   // holds |dividend|, shifted out as quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divout_q, divout_d;
    logic             divzero_q, divzero_d;

    logic             start;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] diff;

    always_comb begin
        start = bus.DivCtrl & ~divctrl_q;
        // Most negative value maps onto itself, read as unsigned 2^(W-1).
        mag_a = bus.RegA[WIDTH-1] ? -bus.RegA : bus.RegA;
        mag_b = bus.RegB[WIDTH-1] ? -bus.RegB : bus.RegB;
        trial = {rem_q, quo_q[WIDTH-1]};
        fits  = trial >= {1'b0, dvs_q};
        // When fits, the true difference is below dvs_q and so fits in WIDTH bits.
        diff  = trial[WIDTH-1:0] - dvs_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divout_d  = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (bus.RegB == '0) begin
                        state_d   = ZERO;
                        divzero_d = 1'b1;
                    end else begin
                        quo_d    = mag_a;
                        dvs_d    = mag_b;
                        sign_q_d = bus.RegA[WIDTH-1] ^ bus.RegB[WIDTH-1];
                        sign_r_d = bus.RegA[WIDTH-1];
                        rem_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = fits ? diff : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], fits};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // First FIX edge publishes the result; the second closes the pulse.
                if (!divout_q) begin
                    hi_d     = sign_r_q ? -rem_q : rem_q;
                    lo_d     = sign_q_q ? -quo_q : quo_q;
                    divout_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ZERO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            divctrl_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divout_q  <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divctrl_q <= bus.DivCtrl;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divout_q  <= divout_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.DivOut  = divout_q;
    assign bus.divZero = divzero_q;
    assign bus.HIOut   = hi_q;
    assign bus.LOOut   = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes the expected response, a monitor
// pops and compares whenever DivOut or divZero is seen.
module tb_div_unit;
    localparam int W = 32;

    typedef struct {
        bit          zero;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every completion/zero pulse against the scoreboard head.
    always @(negedge clk) begin
        if (reset && (bus.DivOut || bus.divZero)) begin
            exp_t e;
            check("pulse_exclusive", {31'b0, bus.DivOut & bus.divZero}, 32'd0);
            check("pulse_expected", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pulse_kind", {31'b0, bus.divZero}, {31'b0, e.zero});
                check("hi", bus.HIOut, e.hi);
                check("lo", bus.LOOut, e.lo);
            end
        end
    end

    // One start pulse; checks the start-edge-to-pulse latency (0 edges for divZero,
    // WIDTH+1 edges for DivOut) and leaves the unit back in IDLE.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input bit zero);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.RegA    = a;
        bus.RegB    = b;
        bus.DivCtrl = 1'b1;
        e.zero = zero;
        e.hi   = hi;
        e.lo   = lo;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.DivCtrl = 1'b0;
        n = 0;
        while (!(bus.DivOut || bus.divZero) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, zero ? 32'd0 : 32'd33);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt;
        exp_t e;
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b0;
        bus.DivCtrl = 1'b0;
        bus.RegA    = '0;
        bus.RegB    = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.HIOut, 32'd0);
        check("rst_lo", bus.LOOut, 32'd0);
        check("rst_divout", {31'b0, bus.DivOut}, 32'd0);
        check("rst_divzero", {31'b0, bus.divZero}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        do_div(-32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_div(32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0);
        do_div(-32'sd100, -32'sd7, 32'hFFFF_FFFE, 32'd14, 1'b0);
        do_div(32'h7FFF_FFFF, 32'd1, 32'd0, 32'h7FFF_FFFF, 1'b0);

        // Zero divisor keeps the previous HI/LO.
        do_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        do_div(32'd5, 32'd0, 32'd2, 32'd14, 1'b1);
        check("zero_keep_hi", bus.HIOut, 32'd2);
        check("zero_keep_lo", bus.LOOut, 32'd14);

        do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        do_div(32'd0, 32'd9, 32'd0, 32'd0, 1'b0);

        // Held-high DivCtrl triggers exactly once.
        @(negedge clk);
        bus.RegA    = 32'd1000;
        bus.RegB    = 32'd10;
        bus.DivCtrl = 1'b1;
        e.zero = 1'b0;
        e.hi   = 32'd0;
        e.lo   = 32'd100;
        sb.push_back(e);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DivOut) cnt++;
        end
        check("held_single_pulse", cnt, 32'd1);
        bus.DivCtrl = 1'b0;
        do_div(-32'sd1003, 32'd10, 32'hFFFF_FFFD, 32'hFFFF_FF9C, 1'b0);

        // A second rising edge during CALC is ignored; latched operands win.
        @(negedge clk);
        bus.RegA    = 32'd100;
        bus.RegB    = 32'd7;
        bus.DivCtrl = 1'b1;
        e.zero = 1'b0;
        e.hi   = 32'd2;
        e.lo   = 32'd14;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        bus.DivCtrl = 1'b0;
        @(negedge clk);
        bus.RegA    = 32'd50;
        bus.RegB    = 32'd5;
        bus.DivCtrl = 1'b1;
        cnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.DivOut) cnt++;
        end
        check("restart_ignored", cnt, 32'd1);
        bus.DivCtrl = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of CALC discards the division.
        do_div(-32'sd1003, 32'd10, 32'hFFFF_FFFD, 32'hFFFF_FF9C, 1'b0);
        @(negedge clk);
        bus.RegA    = 32'd100;
        bus.RegB    = 32'd7;
        bus.DivCtrl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.DivCtrl = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", bus.HIOut, 32'd0);
        check("arst_lo", bus.LOOut, 32'd0);
        check("arst_divout", {31'b0, bus.DivOut}, 32'd0);
        check("arst_divzero", {31'b0, bus.divZero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DivOut || bus.divZero) cnt++;
        end
        check("no_pulse_after_reset", cnt, 32'd0);
        do_div(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
